estacao_reserva_add: RTL and testbench
======================================

Name: estacao_reserva_add

Overview:
- One adder reservation station of the Tomasulo core. It is the consumer end of the dispatch unit's Vj/Vk/Qj/Qk/Enable interface.
- Accepts a dispatched add/sub and snoops the common data bus (CDB) for pending operands.
- Executes once both operands are valid, then requests the CDB and broadcasts the result under its own tag.
- Its free indication drives the dispatch unit's Ready_R1/Ready_R2 input.

Parameters:
- TAG, 3'd1: this station's tag on the CDB and in the register status table; must be nonzero.
- EXEC_LATENCY, 2: execute cycles, range 1..7.
- SEM_VALOR, 16'hFFF0: value placed in V fields while a tag is pending.

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- Enable  in  1  dispatch strobe (Estacao_Reserva_ADDx_Enable)
- Op  in  1  0 = ADD, 1 = SUB (Vj - Vk)
- Vj, Vk  in  16  operand values from dispatch
- Qj, Qk  in  3  producing-station tags; 0 = value valid
- Cdb_Valid  in  1  CDB broadcast valid
- Cdb_Tag  in  3  CDB broadcast tag
- Cdb_Data  in  16  CDB broadcast data
- Cdb_Grant  in  1  arbiter grant for this station
- Ready  out  1  station free (to dispatch Ready_Rx)
- Cdb_Req  out  1  request to broadcast
- Cdb_Out_Tag  out  3  equals TAG while Cdb_Req=1, else 0
- Cdb_Out_Data  out  16  result while Cdb_Req=1, else 0
- Erro_Despacho  out  1  one-cycle pulse: Enable while not free

Behaviour:
Reset (Reset=0, asynchronous):
- State LIVRE, Ready=1, Cdb_Req=0, Cdb_Out_Tag=0, Cdb_Out_Data=0, Erro_Despacho=0.
- Internal Vj/Vk=SEM_VALOR, Qj/Qk=0, counter=0.
- Asserting Reset mid-operation discards the instruction. No broadcast occurs.

States: LIVRE -> ESPERA -> EXEC -> RESULTADO -> LIVRE.

LIVRE:
- Ready=1.
- On Enable, latch Op, Vj, Vk, Qj, Qk.
- Same-cycle bypass: if Cdb_Valid and Cdb_Tag==Qj with Qj!=0, latch Cdb_Data as Vj and set Qj=0. Same rule for k.
- If both resolved tags are 0, go to EXEC with counter=EXEC_LATENCY-1. Otherwise go to ESPERA.

ESPERA:
- Each cycle, on Cdb_Valid && Cdb_Tag==Qj && Qj!=0: Vj<=Cdb_Data, Qj<=0. Same for k. Both may capture in the same cycle.
- Transition to EXEC is evaluated on the registered Q values, so the cycle after the last capture enters EXEC.
- A CDB broadcast with a non-matching tag, or with tag 0, is ignored.

EXEC:
- Decrement the counter each cycle.
- When counter==0, compute the result and go to RESULTADO. Result is Vj+Vk or Vj-Vk, modulo 2^16, with no carry or flag.

RESULTADO:
- Cdb_Req=1, Cdb_Out_Tag=TAG, Cdb_Out_Data=result. All three hold stable until granted.
- A cycle with Cdb_Req && Cdb_Grant is the transfer. The next state is LIVRE, with Ready=1 in the following cycle.
- Cdb_Grant while Cdb_Req=0 is ignored.

Latency:
- Enable at cycle n with ready operands: EXEC during n+1..n+EXEC_LATENCY, Cdb_Req first high at n+EXEC_LATENCY+1.
- With immediate grant, Ready returns at n+EXEC_LATENCY+2.

Ready is combinational from state (state==LIVRE). An Enable in the cycle Ready rises is accepted.

Enable while not LIVRE:
- The instruction is ignored and the station's contents are unchanged.
- Erro_Despacho pulses high for one cycle.

Own broadcast on Cdb_Tag==TAG never matches a pending Q in this station, because the station is busy until it is granted.

Test Plan:
- Ready operands: Enable, Op=0, Vj=16'h0003, Vk=16'h0004, Qj=Qk=0, Cdb_Grant tied 1 -> Cdb_Req high exactly 3 cycles after Enable with Cdb_Out_Data=16'h0007, Cdb_Out_Tag=1; Ready=1 the next cycle.
- Wrap and subtract: Op=1, Vj=16'h0000, Vk=16'h0001 -> Cdb_Out_Data=16'hFFFF. Op=0, Vj=16'hFFFF, Vk=16'h0002 -> Cdb_Out_Data=16'h0001.
- Pending operands:
  - Enable with Qj=2, Vj=16'hFFF0, Vk=16'h0010, Qk=0; station waits.
  - Broadcast tag 3 -> no change.
  - Broadcast tag 2, data 16'h0005 -> station enters EXEC the next cycle; result 16'h0015.
- Bypass and dual capture:
  - Enable in the same cycle as Cdb_Valid, tag 2, data 16'h0009, with Qj=Qk=2 -> both operands captured; result 16'h0012 without further waiting.
- Grant stall: hold Cdb_Grant=0 for 5 cycles in RESULTADO -> Cdb_Req, Cdb_Out_Tag and Cdb_Out_Data stay constant. Grant -> LIVRE next cycle.
- Busy and reset:
  - Enable during ESPERA -> Erro_Despacho one-cycle pulse; latched operands unchanged.
  - Then drive Reset=0 mid-EXEC -> outputs immediately at reset values, no Cdb_Req.

Source files
------------

// File: rtl/estacao_reserva_add.sv
// Adder reservation station for the Tomasulo core.
// Accepts one dispatched ADD/SUB, snoops the CDB for pending operands,
// executes for EXEC_LATENCY cycles, then broadcasts its result on the CDB
// under its own tag.
//
// CDB output handshake: cdb_req_o acts as valid and cdb_grant_i acts as ready.
// While cdb_req_o=1, cdb_out_tag_o and cdb_out_data_o hold stable. A rising
// clock edge that sees cdb_req_o && cdb_grant_i completes the transfer.
// cdb_grant_i has no effect while cdb_req_o=0.
module estacao_reserva_add #(
  parameter logic [2:0]  TAG          = 3'd1,
  parameter int          EXEC_LATENCY = 2,
  parameter logic [15:0] SEM_VALOR    = 16'hFFF0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        op_i,
  input  logic [15:0] vj_i,
  input  logic [15:0] vk_i,
  input  logic [2:0]  qj_i,
  input  logic [2:0]  qk_i,
  input  logic        cdb_valid_i,
  input  logic [2:0]  cdb_tag_i,
  input  logic [15:0] cdb_data_i,
  input  logic        cdb_grant_i,
  output logic        ready_o,
  output logic        cdb_req_o,
  output logic [2:0]  cdb_out_tag_o,
  output logic [15:0] cdb_out_data_o,
  output logic        erro_despacho_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    LIVRE     = 2'd0,
    ESPERA    = 2'd1,
    EXEC      = 2'd2,
    RESULTADO = 2'd3
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(EXEC_LATENCY - 1);

  state_t      state_q, state_d;
  logic        op_q, op_d;
  logic [15:0] vj_q, vj_d;
  logic [15:0] vk_q, vk_d;
  logic [2:0]  qj_q, qj_d;
  logic [2:0]  qk_q, qk_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic        erro_q, erro_d;

  // A CDB broadcast resolves a tag only when the tag is nonzero and matches.
  logic byp_j, byp_k, snp_j, snp_k;
  assign byp_j = cdb_valid_i && (qj_i != 3'd0) && (cdb_tag_i == qj_i);
  assign byp_k = cdb_valid_i && (qk_i != 3'd0) && (cdb_tag_i == qk_i);
  assign snp_j = cdb_valid_i && (qj_q != 3'd0) && (cdb_tag_i == qj_q);
  assign snp_k = cdb_valid_i && (qk_q != 3'd0) && (cdb_tag_i == qk_q);

  // Next-state, operand capture and result computation.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    vj_d     = vj_q;
    vk_d     = vk_q;
    qj_d     = qj_q;
    qk_d     = qk_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    erro_d   = enable_i && (state_q != LIVRE);
    case (state_q)
      LIVRE: begin
        if (enable_i) begin
          op_d  = op_i;
          qj_d  = byp_j ? 3'd0 : qj_i;
          qk_d  = byp_k ? 3'd0 : qk_i;
          vj_d  = byp_j ? cdb_data_i : ((qj_i != 3'd0) ? SEM_VALOR : vj_i);
          vk_d  = byp_k ? cdb_data_i : ((qk_i != 3'd0) ? SEM_VALOR : vk_i);
          cnt_d = CNT_INIT;
          state_d = ((qj_d == 3'd0) && (qk_d == 3'd0)) ? EXEC : ESPERA;
        end
      end
      ESPERA: begin
        if (snp_j) begin
          vj_d = cdb_data_i;
          qj_d = 3'd0;
        end
        if (snp_k) begin
          vk_d = cdb_data_i;
          qk_d = 3'd0;
        end
        // Decided on registered tags: a capture takes effect one cycle later.
        if ((qj_q == 3'd0) && (qk_q == 3'd0)) begin
          state_d = EXEC;
          cnt_d   = CNT_INIT;
        end
      end
      EXEC: begin
        if (cnt_q == 3'd0) begin
          result_d = op_q ? (vj_q - vk_q) : (vj_q + vk_q);
          state_d  = RESULTADO;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESULTADO: begin
        if (cdb_grant_i) state_d = LIVRE;
      end
      default: state_d = LIVRE;
    endcase
  end

  // State and datapath registers; reset discards any instruction in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= LIVRE;
      op_q     <= 1'b0;
      vj_q     <= SEM_VALOR;
      vk_q     <= SEM_VALOR;
      qj_q     <= 3'd0;
      qk_q     <= 3'd0;
      cnt_q    <= 3'd0;
      result_q <= 16'd0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      vj_q     <= vj_d;
      vk_q     <= vk_d;
      qj_q     <= qj_d;
      qk_q     <= qk_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      erro_q   <= erro_d;
    end
  end

  // Outputs decoded from state; CDB fields are zero unless requesting.
  always_comb begin
    ready_o         = (state_q == LIVRE);
    cdb_req_o       = (state_q == RESULTADO);
    cdb_out_tag_o   = cdb_req_o ? TAG : 3'd0;
    cdb_out_data_o  = cdb_req_o ? result_q : 16'd0;
    erro_despacho_o = erro_q;
    state_o         = state_q;
  end

endmodule

// File: tb/tb_estacao_reserva_add.sv
// Testbench for estacao_reserva_add (TAG=1, EXEC_LATENCY=2).
module tb_estacao_reserva_add;

  localparam logic [2:0] TAG = 3'd1;
  localparam logic [1:0] ST_LIVRE  = 2'd0;
  localparam logic [1:0] ST_ESPERA = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam int         WAIT_MAX  = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        enable = 1'b0;
  logic        op = 1'b0;
  logic [15:0] vj = 16'd0, vk = 16'd0;
  logic [2:0]  qj = 3'd0, qk = 3'd0;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = 3'd0;
  logic [15:0] cdb_data = 16'd0;
  logic        cdb_grant = 1'b0;
  logic        ready, cdb_req, erro;
  logic [2:0]  cdb_out_tag;
  logic [15:0] cdb_out_data;
  logic [1:0]  state;

  estacao_reserva_add #(.TAG(3'd1), .EXEC_LATENCY(2), .SEM_VALOR(16'hFFF0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .op_i(op),
    .vj_i(vj), .vk_i(vk), .qj_i(qj), .qk_i(qk),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
    .cdb_grant_i(cdb_grant), .ready_o(ready), .cdb_req_o(cdb_req),
    .cdb_out_tag_o(cdb_out_tag), .cdb_out_data_o(cdb_out_data),
    .erro_despacho_o(erro), .state_o(state)
  );

  int errors = 0;
  int checks = 0;
  logic [18:0] exp_q[$];

  // Reference ALU: 16-bit wrap, no flags.
  function automatic logic [15:0] alu(input logic o, input logic [15:0] a, input logic [15:0] b);
    return o ? (a - b) : (a + b);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic o, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] ta, input logic [2:0] tb);
    op = o; vj = a; vk = b; qj = ta; qk = tb; enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic broadcast(input logic [2:0] t, input logic [15:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    tick();
    cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_data = 16'd0;
  endtask

  // ---------------- scoreboard: compare on each CDB transfer ----------------
  always @(negedge clk) begin
    if (rst_n && cdb_req && cdb_grant) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got tag=%0d data=%h, expected queue empty", cdb_out_tag, cdb_out_data);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({cdb_out_tag, cdb_out_data} !== e) begin
          errors++;
          $display("FAIL sb_transfer: got tag=%0d data=%h, expected tag=%0d data=%h",
                   cdb_out_tag, cdb_out_data, e[18:16], e[15:0]);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", cdb_req); end
    checks++; if (cdb_out_tag !== 3'd0) begin errors++; $display("FAIL reset_tag: got %0d expected 0", cdb_out_tag); end
    checks++; if (cdb_out_data !== 16'd0) begin errors++; $display("FAIL reset_data: got %h expected 0000", cdb_out_data); end
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL reset_erro: got %b expected 0", erro); end
    checks++; if (state !== ST_LIVRE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, ST_LIVRE); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ready_operands();
    cdb_grant = 1'b1;
    exp_q.push_back({TAG, 16'h0007});
    dispatch(1'b0, 16'h0003, 16'h0004, 3'd0, 3'd0);
    // cycle n+1
    checks++; if (state !== ST_EXEC) begin errors++; $display("FAIL ready_ops_exec: got state %0d expected %0d", state, ST_EXEC); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_ops_busy: got ready %b expected 0", ready); end
    tick(); // n+2
    checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL ready_ops_early_req: got %b expected 0", cdb_req); end
    tick(); // n+3
    checks++; if (cdb_req !== 1'b1) begin errors++; $display("FAIL ready_ops_req: got %b expected 1", cdb_req); end
    checks++; if (cdb_out_tag !== TAG) begin errors++; $display("FAIL ready_ops_tag: got %0d expected %0d", cdb_out_tag, TAG); end
    checks++; if (cdb_out_data !== 16'h0007) begin errors++; $display("FAIL ready_ops_data: got %h expected 0007", cdb_out_data); end
    tick(); // n+4
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_ops_free: got %b expected 1", ready); end
  endtask

  // Second dispatch lands in the very cycle Ready rises.
  task automatic test_wrap_sub();
    logic        ops[3];
    logic [15:0] as[3];
    logic [15:0] bs[3];
    ops[0] = 1'b1; as[0] = 16'h0000; bs[0] = 16'h0001;
    ops[1] = 1'b0; as[1] = 16'hFFFF; bs[1] = 16'h0002;
    ops[2] = 1'($urandom_range(0, 1)); as[2] = 16'($urandom_range(0, 65535)); bs[2] = 16'($urandom_range(0, 65535));
    cdb_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n;
      logic [15:0] e;
      e = alu(ops[i], as[i], bs[i]);
      exp_q.push_back({TAG, e});
      dispatch(ops[i], as[i], bs[i], 3'd0, 3'd0);
      n = 0;
      while (!cdb_req && n < WAIT_MAX) begin tick(); n++; end
      checks++;
      if (cdb_req !== 1'b1 || cdb_out_data !== e) begin
        errors++;
        $display("FAIL wrap_sub_%0d: got req=%b data=%h expected req=1 data=%h", i, cdb_req, cdb_out_data, e);
      end
      tick();
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL wrap_sub_free: got %b expected 1", ready); end
  endtask

  task automatic test_pending();
    int n;
    cdb_grant = 1'b1;
    exp_q.push_back({TAG, 16'h0015});
    dispatch(1'b0, 16'hFFF0, 16'h0010, 3'd2, 3'd0);
    checks++; if (state !== ST_ESPERA) begin errors++; $display("FAIL pend_wait: got state %0d expected %0d", state, ST_ESPERA); end
    broadcast(3'd3, 16'h1234);
    broadcast(3'd0, 16'h4321);
    tick();
    checks++;
    if (state !== ST_ESPERA || cdb_req !== 1'b0) begin
      errors++; $display("FAIL pend_ignore: got state %0d req %b expected state %0d req 0", state, cdb_req, ST_ESPERA);
    end
    broadcast(3'd2, 16'h0005);
    n = 0;
    while (state != ST_EXEC && n < 3) begin tick(); n++; end
    checks++; if (state !== ST_EXEC) begin errors++; $display("FAIL pend_exec: got state %0d expected %0d", state, ST_EXEC); end
    n = 0;
    while (!cdb_req && n < WAIT_MAX) begin tick(); n++; end
    checks++;
    if (cdb_req !== 1'b1 || cdb_out_data !== 16'h0015) begin
      errors++; $display("FAIL pend_result: got req=%b data=%h expected req=1 data=0015", cdb_req, cdb_out_data);
    end
    tick();
  endtask

  task automatic test_bypass();
    int n;
    cdb_grant = 1'b1;
    exp_q.push_back({TAG, 16'h0012});
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'h0009;
    dispatch(1'b0, 16'h0000, 16'h0000, 3'd2, 3'd2);
    cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_data = 16'd0;
    checks++; if (state !== ST_EXEC) begin errors++; $display("FAIL bypass_exec: got state %0d expected %0d", state, ST_EXEC); end
    n = 0;
    while (!cdb_req && n < WAIT_MAX) begin tick(); n++; end
    checks++;
    if (cdb_req !== 1'b1 || cdb_out_data !== 16'h0012) begin
      errors++; $display("FAIL bypass_result: got req=%b data=%h expected req=1 data=0012", cdb_req, cdb_out_data);
    end
    tick();
  endtask

  task automatic test_grant_stall();
    int n;
    cdb_grant = 1'b0;
    exp_q.push_back({TAG, 16'h00FF});
    dispatch(1'b1, 16'h0100, 16'h0001, 3'd0, 3'd0);
    n = 0;
    while (!cdb_req && n < WAIT_MAX) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cdb_req !== 1'b1 || cdb_out_tag !== TAG || cdb_out_data !== 16'h00FF) begin
        errors++;
        $display("FAIL stall_hold_%0d: got req=%b tag=%0d data=%h expected req=1 tag=%0d data=00ff",
                 i, cdb_req, cdb_out_tag, cdb_out_data, TAG);
      end
      tick();
    end
    cdb_grant = 1'b1;
    tick();
    checks++;
    if (ready !== 1'b1 || cdb_req !== 1'b0) begin
      errors++; $display("FAIL stall_release: got ready=%b req=%b expected ready=1 req=0", ready, cdb_req);
    end
  endtask

  task automatic test_busy_enable();
    int n;
    cdb_grant = 1'b1;
    exp_q.push_back({TAG, 16'h0033});
    dispatch(1'b0, 16'hFFF0, 16'h0022, 3'd3, 3'd0);
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL busy_no_erro: got %b expected 0", erro); end
    dispatch(1'b1, 16'h0001, 16'h0001, 3'd0, 3'd0);
    checks++; if (erro !== 1'b1) begin errors++; $display("FAIL busy_erro_pulse: got %b expected 1", erro); end
    tick();
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL busy_erro_clear: got %b expected 0", erro); end
    checks++; if (state !== ST_ESPERA) begin errors++; $display("FAIL busy_state: got %0d expected %0d", state, ST_ESPERA); end
    broadcast(3'd3, 16'h0011);
    n = 0;
    while (!cdb_req && n < WAIT_MAX) begin tick(); n++; end
    checks++;
    if (cdb_req !== 1'b1 || cdb_out_data !== 16'h0033) begin
      errors++; $display("FAIL busy_result: got req=%b data=%h expected req=1 data=0033", cdb_req, cdb_out_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_exec();
    int n;
    cdb_grant = 1'b1;
    dispatch(1'b0, 16'h0005, 16'h0006, 3'd0, 3'd0);
    checks++; if (state !== ST_EXEC) begin errors++; $display("FAIL rst_pre_exec: got state %0d expected %0d", state, ST_EXEC); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || cdb_req !== 1'b0 || cdb_out_tag !== 3'd0 || cdb_out_data !== 16'd0 || state !== ST_LIVRE) begin
      errors++;
      $display("FAIL rst_async: got ready=%b req=%b tag=%0d data=%h state=%0d expected 1 0 0 0000 0",
               ready, cdb_req, cdb_out_tag, cdb_out_data, state);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL rst_hold_%0d: got req %b expected 0", i, cdb_req); end
    end
    rst_n = 1'b1;
    tick();
    // Station must be usable again; the discarded add never reaches the CDB.
    exp_q.push_back({TAG, 16'h0101});
    dispatch(1'b0, 16'h00FF, 16'h0002, 3'd0, 3'd0);
    n = 0;
    while (!cdb_req && n < WAIT_MAX) begin tick(); n++; end
    checks++;
    if (cdb_req !== 1'b1 || cdb_out_data !== 16'h0101) begin
      errors++; $display("FAIL rst_after: got req=%b data=%h expected req=1 data=0101", cdb_req, cdb_out_data);
    end
    tick();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_ready_operands();
    test_wrap_sub();
    test_pending();
    test_bypass();
    test_grant_stall();
    test_busy_enable();
    test_reset_mid_exec();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending results expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
